// File: rtl/inst_prefetch_buf_pkg.sv
// inst_prefetch_buf_pkg
// Shared definitions for the instruction prefetch buffer: the NOP that is
// presented while no instruction is valid, the default queue depth, the
// FSM state encodings, the {pc, inst} queue entry and a PC increment helper.
// Optional feature macro used by inst_prefetch_buf: PREFETCH_BYPASS_EN.

package inst_prefetch_buf_pkg;

    // RV32 canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int PF_DEPTH_DEFAULT = 4;

    typedef enum logic {
        PF_IDLE = 1'b0,
        PF_RUN  = 1'b1
    } pf_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } pf_entry_t;

    // Sequential word step; wraps modulo 2^32 naturally
    function automatic logic [31:0] pcInc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_prefetch_buf_fifo.sv
// prefetch_fifo
// Synchronous FIFO of {pc, inst} entries used as the prefetch queue.
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers
// differing only in the wrap bit mean full.
// Ports:
//   clk        core clock
//   rst        synchronous active-low reset
//   push_i     write wrEntry_i (ignored when full or clearing)
//   wrEntry_i  entry to write
//   pop_i      drop the head entry (ignored when empty or clearing)
//   clear_i    empty the queue; wins over push and pop
//   rdEntry_o  head entry (undefined contents when empty)
//   empty_o    queue is empty
//   full_o     queue holds DEPTH entries
//   count_o    current occupancy, 0..DEPTH

module prefetch_fifo
    import inst_prefetch_buf_pkg::*;
#(
    parameter int DEPTH = PF_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  pf_entry_t                wrEntry_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output pf_entry_t                rdEntry_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    pf_entry_t   mem_q [DEPTH];
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    logic        doPush;
    logic        doPop;

    assign doPush = push_i & ~full_o & ~clear_i;
    assign doPop  = pop_i & ~empty_o & ~clear_i;

    // Pointer next-state: clear resets both pointers, otherwise each one
    // advances independently so a push and pop together keep occupancy.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= wrEntry_i;
        end
    end

    assign rdEntry_o = mem_q[rdPtr_q[AW-1:0]];
    assign empty_o   = (wrPtr_q == rdPtr_q);
    assign full_o    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign count_o   = wrPtr_q - rdPtr_q;

endmodule

// File: rtl/inst_prefetch_buf.sv
// inst_prefetch_buf
// Instruction prefetch queue between the instruction-memory port and the
// fetch stage. Issues sequential word fetches ahead of the pipeline, buffers
// returned instructions with their PCs, survives hold stalls and flushes on
// a redirect, discarding any responses still in flight.
// Optional feature macro: PREFETCH_BYPASS_EN -- when defined, a response that
// arrives while the queue is empty and nothing blocks it is forwarded to the
// IF_* outputs in the same cycle instead of being queued.
// Ports:
//   clk, rst         core clock, synchronous active-low reset
//   imem_req_*       fetch request (vld/rdy handshake, word address)
//   imem_rsp_*       in-order response, always accepted
//   hold             downstream stall, head is kept
//   jmp_vld/jmp_addr redirect and target (low two bits ignored)
//   IF_vld/IF_pc/IF_inst  head instruction presented to the fetch stage

module inst_prefetch_buf
    import inst_prefetch_buf_pkg::*;
#(
    parameter int          DEPTH    = PF_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_vld,
    input  logic        imem_req_rdy,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_vld,
    input  logic [31:0] imem_rsp_data,
    input  logic        hold,
    input  logic        jmp_vld,
    input  logic [31:0] jmp_addr,
    output logic        IF_vld,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);

    localparam int CW = $clog2(DEPTH) + 1;

    pf_state_e     state_q, state_d;
    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [31:0]   retPc_q, retPc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] dropCnt_q, dropCnt_d;

    logic [CW-1:0] fifoCount;
    logic          fifoEmpty;
    logic          fifoFull;
    pf_entry_t     headEntry;
    pf_entry_t     pushEntry;

    logic [CW:0]   inFlight;
    logic          creditOk;
    logic          reqFire;
    logic          dropping;
    logic          keepRsp;
    logic          bypassHit;
    logic          pushEn;
    logic          popEn;
    logic [31:0]   jmpTarget;
    logic [1:0]    unusedJmpLsbs;

    assign jmpTarget     = {jmp_addr[31:2], 2'b00};
    assign unusedJmpLsbs = jmp_addr[1:0];

    // Queued plus in-flight work must stay below DEPTH, which guarantees a
    // slot for every response that can come back.
    assign inFlight = {1'b0, fifoCount} + {1'b0, outstanding_q};
    assign creditOk = (inFlight < (CW+1)'(DEPTH));

    assign imem_req_vld  = rst & ~jmp_vld & (state_q == PF_RUN) & creditOk;
    assign imem_req_addr = fetchPc_q;
    assign reqFire       = imem_req_vld & imem_req_rdy;

    // Responses owed to requests issued before a redirect are dropped here.
    assign dropping = (dropCnt_q != '0);
    assign keepRsp  = imem_rsp_vld & ~dropping & ~jmp_vld;

`ifdef PREFETCH_BYPASS_EN
    assign bypassHit = keepRsp & fifoEmpty & ~hold;
`else
    assign bypassHit = 1'b0;
`endif

    assign pushEn         = keepRsp & ~bypassHit & ~fifoFull;
    assign pushEntry.pc   = retPc_q;
    assign pushEntry.inst = imem_rsp_data;
    assign popEn          = ~fifoEmpty & ~hold & ~jmp_vld;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (pushEn),
        .wrEntry_i (pushEntry),
        .pop_i     (popEn),
        .clear_i   (jmp_vld),
        .rdEntry_o (headEntry),
        .empty_o   (fifoEmpty),
        .full_o    (fifoFull),
        .count_o   (fifoCount)
    );

    // FSM: IDLE only lasts for the first cycle out of reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PF_IDLE: state_d = PF_RUN;
            PF_RUN:  state_d = PF_RUN;
            default: state_d = PF_IDLE;
        endcase
    end

    // Address, tag and credit bookkeeping. A redirect retargets both PCs
    // and converts every still-owed response into one to be dropped, while
    // outstanding keeps counting them until they actually return.
    always_comb begin
        fetchPc_d     = fetchPc_q;
        retPc_d       = retPc_q;
        outstanding_d = outstanding_q + CW'(reqFire) - CW'(imem_rsp_vld);
        dropCnt_d     = dropCnt_q;
        if (jmp_vld) begin
            fetchPc_d = jmpTarget;
            retPc_d   = jmpTarget;
            dropCnt_d = outstanding_q - CW'(imem_rsp_vld);
        end else begin
            if (reqFire) begin
                fetchPc_d = pcInc(fetchPc_q);
            end
            if (keepRsp) begin
                retPc_d = pcInc(retPc_q);
            end
            if (imem_rsp_vld && dropping) begin
                dropCnt_d = dropCnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= PF_IDLE;
            fetchPc_q     <= RESET_PC;
            retPc_q       <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetchPc_q     <= fetchPc_d;
            retPc_q       <= retPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
        end
    end

    // Fetch-stage view: queue head, or a NOP with PC 0 when empty.
    always_comb begin
        IF_vld  = ~fifoEmpty;
        IF_pc   = fifoEmpty ? 32'h0 : headEntry.pc;
        IF_inst = fifoEmpty ? INST_NOP : headEntry.inst;
`ifdef PREFETCH_BYPASS_EN
        if (bypassHit) begin
            IF_vld  = 1'b1;
            IF_pc   = retPc_q;
            IF_inst = imem_rsp_data;
        end
`endif
    end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// tb_inst_prefetch_buf
// Directed bench for inst_prefetch_buf (DEPTH=4, RESET_PC=0). A small
// instruction memory answers each accepted request after memLat cycles with
// the word memWord(addr); scenarios check reset, streaming, stall, redirect,
// jump during hold, address wrap and mid-run reset.

module tb_inst_prefetch_buf;
    import inst_prefetch_buf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_vld;
    logic        imem_req_rdy = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_vld = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        hold = 1'b0;
    logic        jmp_vld = 1'b0;
    logic [31:0] jmp_addr = 32'h0;
    logic        IF_vld;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;

    int          checks = 0;
    int          passes = 0;
    int          memLat = 1;
    int          cyc = 0;
    logic [31:0] expPc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;
    memReq_t pend[$];

    inst_prefetch_buf dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_vld  (imem_req_vld),
        .imem_req_rdy  (imem_req_rdy),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_vld  (imem_rsp_vld),
        .imem_rsp_data (imem_rsp_data),
        .hold          (hold),
        .jmp_vld       (jmp_vld),
        .jmp_addr      (jmp_addr),
        .IF_vld        (IF_vld),
        .IF_pc         (IF_pc),
        .IF_inst       (IF_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: decides this cycle's response, then records the request
    // the DUT will accept at the coming rising edge. Reset empties it.
    always @(negedge clk) begin
        memReq_t r;
        cyc++;
        if (!rst) begin
            pend.delete();
            imem_rsp_vld  = 1'b0;
            imem_rsp_data = 32'h0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_vld  = 1'b1;
                imem_rsp_data = memWord(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_vld = 1'b0;
            end
            if (imem_req_vld && imem_req_rdy) begin
                r.addr = imem_req_addr;
                r.due  = cyc + memLat;
                pend.push_back(r);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; hold = 1'b0; jmp_vld = 1'b0; jmp_addr = 32'h0; memLat = 1;
        repeat (3) nextCycle();
        #1;
        checks++; if (imem_req_vld !== 1'b0) $display("[TB] FAIL reset_req_vld: got %b want 0", imem_req_vld); else passes++;
        checks++; if (imem_req_addr !== 32'h0) $display("[TB] FAIL reset_req_addr: got %h want 00000000", imem_req_addr); else passes++;
        checks++; if (IF_vld !== 1'b0) $display("[TB] FAIL reset_IF_vld: got %b want 0", IF_vld); else passes++;
        checks++; if (IF_pc !== 32'h0) $display("[TB] FAIL reset_IF_pc: got %h want 00000000", IF_pc); else passes++;
        checks++; if (IF_inst !== 32'h0000_0013) $display("[TB] FAIL reset_IF_inst: got %h want 00000013", IF_inst); else passes++;
    endtask

    task automatic test_reset_run();
        logic        expV;
        logic [31:0] expAddr;
        nextCycle(); rst = 1'b1; #1;
        checks++; if (imem_req_vld !== 1'b0) $display("[TB] FAIL run_idle_req: got %b want 0", imem_req_vld); else passes++;
        nextCycle(); #1;
        checks++; if (imem_req_vld !== 1'b1) $display("[TB] FAIL run_first_req_vld: got %b want 1", imem_req_vld); else passes++;
        checks++; if (imem_req_addr !== 32'h0) $display("[TB] FAIL run_first_req_addr: got %h want 00000000", imem_req_addr); else passes++;
        expPc = 32'h0;
        for (int k = 2; k <= 13; k++) begin
            nextCycle(); #1;
            if (k <= 4) begin
                expAddr = 32'(4 * (k - 1));
                checks++; if (imem_req_vld !== 1'b1) $display("[TB] FAIL run_req_vld: got %b want 1", imem_req_vld); else passes++;
                checks++; if (imem_req_addr !== expAddr) $display("[TB] FAIL run_req_addr: got %h want %h", imem_req_addr, expAddr); else passes++;
            end
            if (k == 3) begin
                checks++; if (IF_inst !== 32'h1357_9BDF) $display("[TB] FAIL run_first_inst: got %h want 13579bdf", IF_inst); else passes++;
            end
            expV = (k >= 3);
            checks++; if (IF_vld !== expV) $display("[TB] FAIL run_IF_vld: got %b want %b", IF_vld, expV); else passes++;
            if (IF_vld === 1'b1 && expV) begin
                checks++; if (IF_pc !== expPc) $display("[TB] FAIL run_IF_pc: got %h want %h", IF_pc, expPc); else passes++;
                checks++; if (IF_inst !== memWord(expPc)) $display("[TB] FAIL run_IF_inst: got %h want %h", IF_inst, memWord(expPc)); else passes++;
                expPc = expPc + 32'd4;
            end
        end
    endtask

    task automatic test_stall_fill();
        for (int i = 0; i < 10; i++) begin
            nextCycle(); hold = 1'b1; #1;
        end
        checks++; if (IF_vld !== 1'b1) $display("[TB] FAIL stall_IF_vld: got %b want 1", IF_vld); else passes++;
        checks++; if (IF_pc !== expPc) $display("[TB] FAIL stall_head_pc: got %h want %h", IF_pc, expPc); else passes++;
        checks++; if (imem_req_vld !== 1'b0) $display("[TB] FAIL stall_req_vld: got %b want 0", imem_req_vld); else passes++;
        for (int i = 0; i < 12; i++) begin
            nextCycle(); hold = 1'b0; #1;
            checks++; if (IF_vld !== 1'b1) $display("[TB] FAIL stall_release_vld: got %b want 1", IF_vld); else passes++;
            if (IF_vld === 1'b1) begin
                checks++; if (IF_pc !== expPc) $display("[TB] FAIL stall_release_pc: got %h want %h", IF_pc, expPc); else passes++;
                checks++; if (IF_inst !== memWord(expPc)) $display("[TB] FAIL stall_release_inst: got %h want %h", IF_inst, memWord(expPc)); else passes++;
                expPc = expPc + 32'd4;
            end
        end
    endtask

    task automatic test_redirect();
        int firstJ = -1;
        memLat = 3;
        for (int i = 0; i < 6; i++) begin
            nextCycle(); #1;
            if (IF_vld === 1'b1) begin
                checks++; if (IF_pc !== expPc) $display("[TB] FAIL redir_pre_pc: got %h want %h", IF_pc, expPc); else passes++;
                expPc = expPc + 32'd4;
            end
        end
        nextCycle(); jmp_vld = 1'b1; jmp_addr = 32'h0000_0103; #1;
        checks++; if (imem_req_vld !== 1'b0) $display("[TB] FAIL redir_req_in_jump: got %b want 0", imem_req_vld); else passes++;
        nextCycle(); jmp_vld = 1'b0; #1;
        checks++; if (IF_vld !== 1'b0) $display("[TB] FAIL redir_IF_vld: got %b want 0", IF_vld); else passes++;
        checks++; if (imem_req_addr !== 32'h0000_0100) $display("[TB] FAIL redir_req_addr: got %h want 00000100", imem_req_addr); else passes++;
        expPc = 32'h0000_0100;
        for (int j = 1; j <= 20; j++) begin
            nextCycle(); #1;
            if (IF_vld === 1'b1) begin
                if (firstJ < 0) firstJ = j;
                checks++; if (IF_pc !== expPc) $display("[TB] FAIL redir_pc: got %h want %h", IF_pc, expPc); else passes++;
                checks++; if (IF_inst !== memWord(expPc)) $display("[TB] FAIL redir_inst: got %h want %h", IF_inst, memWord(expPc)); else passes++;
                expPc = expPc + 32'd4;
            end
        end
        checks++; if (firstJ < 4 || firstJ > 12) $display("[TB] FAIL redir_first_latency: got %0d want 4..12", firstJ); else passes++;
        checks++; if (expPc < 32'h0000_0110) $display("[TB] FAIL redir_progress: got next pc %h want >= 00000110", expPc); else passes++;
    endtask

    task automatic test_jump_hold();
        int seen = 0;
        memLat = 1;
        for (int i = 0; i < 5; i++) begin
            nextCycle(); hold = 1'b1; #1;
        end
        nextCycle(); hold = 1'b1; jmp_vld = 1'b1; jmp_addr = 32'h0000_0200; #1;
        nextCycle(); hold = 1'b0; jmp_vld = 1'b0; #1;
        checks++; if (IF_vld !== 1'b0) $display("[TB] FAIL jh_IF_vld: got %b want 0", IF_vld); else passes++;
        checks++; if (imem_req_addr !== 32'h0000_0200) $display("[TB] FAIL jh_req_addr: got %h want 00000200", imem_req_addr); else passes++;
        expPc = 32'h0000_0200;
        for (int j = 1; j <= 10; j++) begin
            nextCycle(); #1;
            if (IF_vld === 1'b1) begin
                checks++; if (IF_pc !== expPc) $display("[TB] FAIL jh_pc: got %h want %h", IF_pc, expPc); else passes++;
                expPc = expPc + 32'd4;
                seen++;
            end
        end
        checks++; if (seen < 5) $display("[TB] FAIL jh_progress: got %0d instrs want >= 5", seen); else passes++;
    endtask

    task automatic test_wrap();
        logic [31:0] got [3];
        int          n = 0;
        nextCycle(); jmp_vld = 1'b1; jmp_addr = 32'hFFFF_FFF8; #1;
        nextCycle(); jmp_vld = 1'b0; #1;
        expPc = 32'hFFFF_FFF8;
        for (int j = 1; j <= 10; j++) begin
            nextCycle(); #1;
            if (IF_vld === 1'b1) begin
                checks++; if (IF_pc !== expPc) $display("[TB] FAIL wrap_seq_pc: got %h want %h", IF_pc, expPc); else passes++;
                if (n < 3) got[n] = IF_pc;
                n++;
                expPc = expPc + 32'd4;
            end
        end
        checks++; if (got[0] !== 32'hFFFF_FFF8) $display("[TB] FAIL wrap_pc0: got %h want fffffff8", got[0]); else passes++;
        checks++; if (got[1] !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_pc1: got %h want fffffffc", got[1]); else passes++;
        checks++; if (got[2] !== 32'h0000_0000) $display("[TB] FAIL wrap_pc2: got %h want 00000000", got[2]); else passes++;
    endtask

    task automatic test_mid_reset();
        int n = 0;
        for (int i = 0; i < 2; i++) begin
            nextCycle(); hold = 1'b1; #1;
        end
        nextCycle(); rst = 1'b0; hold = 1'b0; #1;
        checks++; if (imem_req_vld !== 1'b0) $display("[TB] FAIL mr_req_in_reset: got %b want 0", imem_req_vld); else passes++;
        nextCycle(); rst = 1'b1; #1;
        checks++; if (imem_req_vld !== 1'b0) $display("[TB] FAIL mr_req_vld: got %b want 0", imem_req_vld); else passes++;
        checks++; if (imem_req_addr !== 32'h0) $display("[TB] FAIL mr_req_addr: got %h want 00000000", imem_req_addr); else passes++;
        checks++; if (IF_vld !== 1'b0) $display("[TB] FAIL mr_IF_vld: got %b want 0", IF_vld); else passes++;
        checks++; if (IF_pc !== 32'h0) $display("[TB] FAIL mr_IF_pc: got %h want 00000000", IF_pc); else passes++;
        checks++; if (IF_inst !== 32'h0000_0013) $display("[TB] FAIL mr_IF_inst: got %h want 00000013", IF_inst); else passes++;
        nextCycle(); #1;
        checks++; if (imem_req_vld !== 1'b1) $display("[TB] FAIL mr_restart_vld: got %b want 1", imem_req_vld); else passes++;
        checks++; if (imem_req_addr !== 32'h0) $display("[TB] FAIL mr_restart_addr: got %h want 00000000", imem_req_addr); else passes++;
        expPc = 32'h0;
        for (int j = 1; j <= 8; j++) begin
            nextCycle(); #1;
            if (IF_vld === 1'b1) begin
                checks++; if (IF_pc !== expPc) $display("[TB] FAIL mr_pc: got %h want %h", IF_pc, expPc); else passes++;
                expPc = expPc + 32'd4;
                n++;
            end
        end
        checks++; if (n < 5) $display("[TB] FAIL mr_progress: got %0d instrs want >= 5", n); else passes++;
    endtask

    initial begin
        test_reset();
        test_reset_run();
        test_stall_fill();
        test_redirect();
        test_jump_hold();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/inst_prefetch_buf.md
# inst_prefetch_buf

Instruction prefetch queue between the instruction-memory port and the fetch stage of the RV32 core. It issues sequential word fetches ahead of the pipeline and buffers returned instructions with their PCs. It absorbs `hold` stalls from Control without losing in-flight data, and flushes cleanly on a redirect (`jmp_vld`). Downstream it presents `IF_pc`/`IF_inst` plus a valid flag, replacing the direct memory read inside the fetch stage.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2–16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-low reset.
- `imem_req_vld`  out  1  fetch request valid.
- `imem_req_rdy`  in  1  memory accepts request; transfer on `vld & rdy`.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_vld`  in  1  response valid; responses return in order, at least 1 cycle after acceptance; always accepted.
- `imem_rsp_data`  in  32  instruction word.
- `hold`  in  1  downstream stall; head is not consumed.
- `jmp_vld`  in  1  redirect / flush.
- `jmp_addr`  in  32  redirect target; bits [1:0] ignored.
- `IF_vld`  out  1  `IF_pc`/`IF_inst` hold a valid instruction.
- `IF_pc`  out  32  PC of head instruction.
- `IF_inst`  out  32  head instruction; `INST_NOP` (32'h0000_0013) when `IF_vld`=0.

## Operation
- **Queue:** `DEPTH` entries of {pc, inst}. Read and write pointers carry an extra wrap bit. Empty when pointers are equal; full when only the wrap bits differ.
- **Counters:**
  - `fetch_pc`: next request address. Advances by 4 on each accepted request and wraps modulo 2^32.
  - `outstanding` (0..`DEPTH`): accepted requests not yet returned.
  - `drop_cnt` (0..`DEPTH`): in-flight responses to discard.
- **Credit rule:** `imem_req_vld` = 1 only when all of these hold:
  - `rst` is high;
  - `jmp_vld` = 0;
  - FSM is in RUN;
  - occupancy + `outstanding` < `DEPTH`.
  
  Because of this rule the queue can never overflow.
- **Response handling:**
  - If `drop_cnt` > 0: discard the response and decrement `drop_cnt`.
  - Otherwise: push {pc-tag, data}. The pc-tag comes from a return-PC register that advances by 4 per kept response.
- **Pop:** when `IF_vld & ~hold & ~jmp_vld`.
- **Redirect (`jmp_vld`=1) has priority over everything:**
  - queue cleared;
  - `fetch_pc` and the return-PC register set to {`jmp_addr`[31:2], 2'b00};
  - no request issued that cycle;
  - any response in that cycle is discarded;
  - `drop_cnt` <= `outstanding` − `imem_rsp_vld`, so every remaining in-flight response is doomed;
  - `outstanding` itself keeps counting until those responses return.
- **Simultaneous events:** push and pop in the same cycle leave occupancy unchanged. `hold` together with `jmp_vld` means the jump wins. A response and an accepted request in the same cycle leave `outstanding` unchanged.
- **FSM:**
  - IDLE (the reset state) moves to RUN on the first cycle with `rst`=1.
  - RUN issues requests.
  - There is no other state.
  - Reset mid-operation returns to IDLE with all counters zeroed. The system resets the instruction memory together with this block, so no stale responses return after reset.

## Timing
- **Reset values:**
  - `imem_req_vld`=0, `imem_req_addr`=`RESET_PC`;
  - `IF_vld`=0, `IF_pc`=0, `IF_inst`=`INST_NOP`;
  - all pointers and counters 0.
- **First request:** asserted in the 2nd cycle after `rst` rises (IDLE → RUN).
- **Latency:** a response arriving in cycle t is written at the t edge and visible as `IF_vld`=1 in cycle t+1.
- **Redirect:** in the cycle after `jmp_vld`, `IF_vld`=0 and `imem_req_addr`=target. The first target instruction appears no earlier than (memory latency + 1) cycles after its request is accepted.
- **Back-pressure:** with zero-latency-stall memory and no `hold`, sustained throughput is 1 instr/cycle once `DEPTH` ≥ memory latency + 1.

## Configuration
- `PREFETCH_BYPASS_EN` defined: when the queue is empty, `drop_cnt`=0, `imem_rsp_vld`=1, `hold`=0 and `jmp_vld`=0, the response drives `IF_vld`/`IF_pc`/`IF_inst` combinationally in the same cycle and is not written to the queue. Response-to-output latency is 0.
- Undefined: all responses pass through the queue with 1-cycle latency, and all outputs come from the queue only.

## Structure
- Shared `defines.v` gains:
  - `INST_NOP`;
  - `PF_DEPTH_DEFAULT`;
  - the FSM state encodings (`PF_IDLE`, `PF_RUN`).
- One sub-module, `prefetch_fifo`: a synchronous {pc, inst} FIFO with push, pop, clear, empty, full and count.
- Request, credit and drop logic stays in the top.

## Test plan
- **Reset then run:** release `rst` with 1-cycle memory and `hold`=0 → requests to 0x0, 0x4, 0x8…; `IF_vld` first high with `IF_pc`=0x0, then one instruction per cycle.
- **Stall fill:** hold `hold`=1 for 10 cycles with `DEPTH`=4 → at most 4 buffered plus 0 outstanding; `imem_req_vld` drops; after release, PCs continue in order with no gap or duplicate.
- **Redirect with 3-cycle memory:** `jmp_vld` with `jmp_addr`=0x103 while 2 requests are in flight → both responses dropped; next `IF_pc`=0x100; no old-PC instruction ever has `IF_vld`=1.
- **Jump during hold:** `hold`=1 and `jmp_vld`=1 in the same cycle → queue flushed; fetch restarts at the target.
- **Wrap-around:** `jmp_addr`=0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Mid-run reset:** assert `rst`=0 for 1 cycle while the queue is half full → all outputs at reset values next cycle; fetch restarts at `RESET_PC`.
